spi_slave: RTL

SPI target-side peripheral: the responder counterpart to the SPI master, sitting on the same 8-bit strobe-decoded register bus. Oversamples an external SCK/SS/MOSI in the i_PCLK domain, supports all four CPOL/CPHA modes, and handles 8-bit MSB-first frames. Back-to-back bytes within one SS assertion are supported. Exposes TX-holding, RX, CONFIG and STATE registers with sticky overrun/underrun flags.

---
 rtl/spi_pkg.sv | 49 ++++
 rtl/spi_slave_sync.sv | 32 +++
 rtl/spi_slave.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI target peripheral: register bit
// positions, reset values, SPI mode encodings and the framing FSM states.
package spi_pkg;

    localparam int CFG_EN_BIT      = 0;
    localparam int CFG_CPHA_BIT    = 4;
    localparam int CFG_CPOL_BIT    = 5;
    localparam int CFG_IRQ_RX_BIT  = 6;
    localparam int CFG_IRQ_ERR_BIT = 7;

    localparam int ST_RX_VALID_BIT = 0;
    localparam int ST_TX_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT     = 2;
    localparam int ST_OVERRUN_BIT  = 3;
    localparam int ST_UNDERRUN_BIT = 4;

    localparam logic [7:0] CONFIG_RST = 8'h00;
    localparam logic [7:0] STATE_RST  = 8'h02;

    // Encoded as {CPOL, CPHA}.
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic [1:0] {
        FSM_DISARM = 2'd0,
        FSM_IDLE   = 2'd1,
        FSM_FRAME  = 2'd2
    } fsm_state_t;

    function automatic logic [7:0] pack_state(input logic rx_valid,
                                              input logic tx_empty,
                                              input logic busy,
                                              input logic overrun,
                                              input logic underrun);
        logic [7:0] s;
        s                  = 8'h00;
        s[ST_RX_VALID_BIT] = rx_valid;
        s[ST_TX_EMPTY_BIT] = tx_empty;
        s[ST_BUSY_BIT]     = busy;
        s[ST_OVERRUN_BIT]  = overrun;
        s[ST_UNDERRUN_BIT] = underrun;
        return s;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, followed by an
// edge-detect flop that yields single-cycle rise/fall pulses.
module spi_slave_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target peripheral on the strobe-decoded 8-bit register bus: all four
// CPOL/CPHA modes, MSB-first bytes. Define SPI_SLAVE_IRQ_EN to add o_IRQ.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       i_PCLK,
    input  logic       i_PRESETn,
    input  logic       i_WR0,
    input  logic       i_WR1,
    input  logic       i_DR0,
    input  logic       i_DR1,
    input  logic       i_DR2,
    input  logic [7:0] i_PWDATA,
    output logic [7:0] o_PRDATA,
    input  logic       i_SCK,
    input  logic       i_SS,
    input  logic       i_MOSI,
    output logic       o_MISO,
    output logic       o_MISO_OE,
    output logic [1:0] o_DBG_STATE
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic       o_IRQ
`endif
);

    fsm_state_t state_q, state_d;
    logic [7:0] cfg_q, cfg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_empty_q, tx_empty_d;
    logic [7:0] rx_q, rx_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic [7:0] prdata_q, prdata_d;

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i  (i_PCLK),
        .rst_ni (i_PRESETn),
        .d_i    (i_SCK),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i  (i_PCLK),
        .rst_ni (i_PRESETn),
        .d_i    (i_SS),
        .q_o    (ss_s),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // MOSI has the same latency as SCK so it is sampled as it was at the SCK edge.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic      enable, cpol, cpha;
    spi_mode_t mode;
    logic      sck_edge, lead_edge, trail_edge;

    assign enable = cfg_q[CFG_EN_BIT];
    assign mode   = spi_mode_t'({cfg_q[CFG_CPOL_BIT], cfg_q[CFG_CPHA_BIT]});

    always_comb begin
        cpol = 1'b0;
        cpha = 1'b0;
        unique case (mode)
            SPI_MODE0: begin cpol = 1'b0; cpha = 1'b0; end
            SPI_MODE1: begin cpol = 1'b0; cpha = 1'b1; end
            SPI_MODE2: begin cpol = 1'b1; cpha = 1'b0; end
            SPI_MODE3: begin cpol = 1'b1; cpha = 1'b1; end
            default:   begin cpol = 1'b0; cpha = 1'b0; end
        endcase
    end

    // After any edge the new SCK level tells leading (away from idle) from trailing.
    assign sck_edge   = sck_rise | sck_fall;
    assign lead_edge  = sck_edge & (sck_s != cpol);
    assign trail_edge = sck_edge & (sck_s == cpol);

    logic [4:0] strb;
    logic       strb_ok, wr_cfg, wr_tx, rd_state, rd_rx, rd_cfg;

    assign strb     = {i_DR2, i_DR1, i_DR0, i_WR1, i_WR0};
    assign strb_ok  = $onehot(strb);
    assign wr_cfg   = strb_ok & i_WR0;
    assign wr_tx    = strb_ok & i_WR1;
    assign rd_state = strb_ok & i_DR0;
    assign rd_rx    = strb_ok & i_DR1;
    assign rd_cfg   = strb_ok & i_DR2;

    logic [7:0] state_val, rx_byte;
    logic       do_load, do_shift, do_sample, byte_done;

    assign state_val = pack_state(rx_valid_q, tx_empty_q, state_q == FSM_FRAME,
                                  overrun_q, underrun_q);
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_empty_d = tx_empty_q;
        rx_d       = rx_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        prdata_d   = prdata_q;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        byte_done  = 1'b0;

        unique case (state_q)
            FSM_DISARM: begin
                if (enable && ss_s) begin
                    state_d = FSM_IDLE;
                end
            end
            FSM_IDLE: begin
                if (!enable) begin
                    state_d = FSM_DISARM;
                end else if (ss_fall) begin
                    state_d   = FSM_FRAME;
                    bit_cnt_d = 3'd0;
                    do_load   = !cpha;
                end
            end
            FSM_FRAME: begin
                // SS release wins over a coincident SCK edge: nothing more is loaded or sampled.
                if (!enable) begin
                    state_d   = FSM_DISARM;
                    bit_cnt_d = 3'd0;
                end else if (ss_rise) begin
                    state_d   = FSM_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (cpha) begin
                    do_load   = lead_edge && (bit_cnt_q == 3'd0);
                    do_shift  = lead_edge && (bit_cnt_q != 3'd0);
                    do_sample = trail_edge;
                end else begin
                    do_sample = lead_edge;
                    do_load   = trail_edge && (bit_cnt_q == 3'd0);
                    do_shift  = trail_edge && (bit_cnt_q != 3'd0);
                end
            end
            default: state_d = FSM_DISARM;
        endcase

        if (do_sample) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_done  = (bit_cnt_q == 3'd7);
        end

        if (rd_rx) begin
            rx_valid_d = 1'b0;
        end
        if (rd_state) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
        // A byte finishing alongside an RX read is accepted, not counted as overrun.
        if (byte_done) begin
            if (rx_valid_q && !rd_rx) begin
                overrun_d = 1'b1;
            end else begin
                rx_d       = rx_byte;
                rx_valid_d = 1'b1;
            end
        end

        if (do_load) begin
            tx_shift_d = tx_empty_q ? FILL_BYTE : tx_hold_q;
            tx_empty_d = 1'b1;
            if (tx_empty_q) begin
                underrun_d = 1'b1;
            end
        end
        if (do_shift) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
        if (wr_tx) begin
            tx_hold_d  = i_PWDATA;
            tx_empty_d = 1'b0;
        end
        if (wr_cfg) begin
            cfg_d = i_PWDATA;
        end

        if (rd_state) begin
            prdata_d = state_val;
        end else if (rd_rx) begin
            prdata_d = rx_q;
        end else if (rd_cfg) begin
            prdata_d = cfg_q;
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_q    <= FSM_DISARM;
            cfg_q      <= CONFIG_RST;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 8'hFF;
            rx_shift_q <= 8'h00;
            tx_hold_q  <= 8'h00;
            tx_empty_q <= STATE_RST[ST_TX_EMPTY_BIT];
            rx_q       <= 8'h00;
            rx_valid_q <= STATE_RST[ST_RX_VALID_BIT];
            overrun_q  <= STATE_RST[ST_OVERRUN_BIT];
            underrun_q <= STATE_RST[ST_UNDERRUN_BIT];
            prdata_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_hold_q  <= tx_hold_d;
            tx_empty_q <= tx_empty_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            prdata_q   <= prdata_d;
        end
    end

    assign o_PRDATA    = prdata_q;
    assign o_MISO      = tx_shift_q[7];
    assign o_MISO_OE   = enable & (state_q == FSM_FRAME);
    assign o_DBG_STATE = state_q;

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (cfg_q[CFG_IRQ_RX_BIT] & rx_valid_q)
                 | (cfg_q[CFG_IRQ_ERR_BIT] & (overrun_q | underrun_q));

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_IRQ = irq_q;
`endif

endmodule
